// File: rtl/generatore_mosse_pkg.sv
// Shared types, codes and helpers for the rock-paper-scissors move generator.
package generatore_mosse_pkg;

    localparam int unsigned LFSR_W = 8;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [1:0] {
        NESSUNA = 2'b00,
        SASSO   = 2'b01,
        CARTA   = 2'b10,
        FORBICE = 2'b11
    } mossa_t;

    localparam logic [1:0] MANCHE_NESSUNA = 2'b00;
    localparam logic [1:0] MANCHE_PRIMO   = 2'b01;
    localparam logic [1:0] MANCHE_SECONDO = 2'b10;
    localparam logic [1:0] MANCHE_PARI    = 2'b11;

    localparam logic [1:0] PARTITA_IN_CORSO = 2'b00;
    localparam logic [1:0] PARTITA_PRIMO    = 2'b01;
    localparam logic [1:0] PARTITA_SECONDO  = 2'b10;
    localparam logic [1:0] PARTITA_PARI     = 2'b11;
    localparam logic [1:0] VINC_TIMEOUT     = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_PLAY  = 2'b10,
        S_DONE  = 2'b11
    } stato_t;

    // An all-zero seed would lock the LFSR, so it is forced to 1.
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? LFSR_W'(1) : s;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic mossa_t to_move(input logic [LFSR_W-1:0] l);
        logic [1:0] b;
        b = l[1:0];
        return (b == 2'b00) ? SASSO : mossa_t'(b);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR with seed reload and step enable.
module lfsr8
    import generatore_mosse_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'h01
)(
    input  logic              clk,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              en_i,
    output logic [LFSR_W-1:0] lfsr_o
);

    localparam logic [LFSR_W-1:0] SEED_EFF = seed_fix(SEED);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED_EFF;
        end else if (en_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/generatore_mosse.sv
// Match sequencer: drives pseudo-random move pairs, tallies rounds and latches the result.
module generatore_mosse
    import generatore_mosse_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_1     = 8'hA5,
    parameter logic [LFSR_W-1:0] SEED_2     = 8'h3C,
    parameter int unsigned       MAX_MANCHE = 31
)(
    input  logic             clk,
    input  logic             RESET,
    input  logic             AVVIA,
    input  logic [1:0]       MANCHE,
    input  logic [1:0]       PARTITA,
    output logic [1:0]       PRIMO,
    output logic [1:0]       SECONDO,
    output logic             INIZIA,
    output logic             IN_CORSO,
    output logic             FINE,
    output logic [1:0]       VINCITORE,
    output logic             TIMEOUT,
    output logic [CNT_W-1:0] N_MANCHE,
    output logic [CNT_W-1:0] VITTORIE_1,
    output logic [CNT_W-1:0] VITTORIE_2
);

    localparam logic [LFSR_W-1:0] SEED1_EFF = seed_fix(SEED_1);
    localparam logic [LFSR_W-1:0] SEED2_EFF = seed_fix(SEED_2);
    localparam logic [CNT_W-1:0]  MAX_N     = CNT_W'(MAX_MANCHE);

    stato_t            stato_q, stato_d;
    logic [1:0]        primo_q, primo_d, secondo_q, secondo_d;
    logic              inizia_q, inizia_d, in_corso_q, in_corso_d;
    logic              fine_q, fine_d, timeout_q, timeout_d;
    logic [1:0]        vinc_q, vinc_d;
    logic [CNT_W-1:0]  n_q, n_d, v1_q, v1_d, v2_q, v2_d;
    logic [LFSR_W-1:0] lfsr1, lfsr2;
    logic              load_c, en_c;

    assign load_c = (stato_q == S_IDLE) || (stato_q == S_DONE);
    assign en_c   = (stato_q == S_START) || (stato_q == S_PLAY);

    lfsr8 #(.SEED(SEED_1)) u_lfsr_1 (
        .clk    (clk),
        .rst_i  (RESET),
        .load_i (load_c),
        .en_i   (en_c),
        .lfsr_o (lfsr1)
    );

    lfsr8 #(.SEED(SEED_2)) u_lfsr_2 (
        .clk    (clk),
        .rst_i  (RESET),
        .load_i (load_c),
        .en_i   (en_c),
        .lfsr_o (lfsr2)
    );

    // Moves are registered from the LFSR value the same edge will load.
    always_comb begin
        stato_d    = stato_q;
        primo_d    = NESSUNA;
        secondo_d  = NESSUNA;
        inizia_d   = 1'b0;
        in_corso_d = 1'b0;
        fine_d     = fine_q;
        timeout_d  = timeout_q;
        vinc_d     = vinc_q;
        n_d        = n_q;
        v1_d       = v1_q;
        v2_d       = v2_q;

        case (stato_q)
            S_IDLE, S_DONE: begin
                if (AVVIA) begin
                    stato_d   = S_START;
                    inizia_d  = 1'b1;
                    primo_d   = to_move(SEED1_EFF);
                    secondo_d = to_move(SEED2_EFF);
                    fine_d    = 1'b0;
                    timeout_d = 1'b0;
                    vinc_d    = 2'b00;
                    n_d       = '0;
                    v1_d      = '0;
                    v2_d      = '0;
                end
            end
            S_START: begin
                stato_d    = S_PLAY;
                in_corso_d = 1'b1;
                primo_d    = to_move(lfsr_next(lfsr1));
                secondo_d  = to_move(lfsr_next(lfsr2));
            end
            S_PLAY: begin
                in_corso_d = 1'b1;
                primo_d    = to_move(lfsr_next(lfsr1));
                secondo_d  = to_move(lfsr_next(lfsr2));
                if (MANCHE != MANCHE_NESSUNA) n_d  = sat_inc(n_q);
                if (MANCHE == MANCHE_PRIMO)   v1_d = sat_inc(v1_q);
                if (MANCHE == MANCHE_SECONDO) v2_d = sat_inc(v2_q);
                // A real match result beats the round-limit timeout.
                if (PARTITA != PARTITA_IN_CORSO) begin
                    stato_d = S_DONE;
                    vinc_d  = PARTITA;
                end else if ((MANCHE != MANCHE_NESSUNA) && (n_d >= MAX_N)) begin
                    stato_d   = S_DONE;
                    timeout_d = 1'b1;
                    vinc_d    = VINC_TIMEOUT;
                end
                if (stato_d == S_DONE) begin
                    fine_d     = 1'b1;
                    in_corso_d = 1'b0;
                    primo_d    = NESSUNA;
                    secondo_d  = NESSUNA;
                end
            end
            default: stato_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            stato_q    <= S_IDLE;
            primo_q    <= 2'b00;
            secondo_q  <= 2'b00;
            inizia_q   <= 1'b0;
            in_corso_q <= 1'b0;
            fine_q     <= 1'b0;
            timeout_q  <= 1'b0;
            vinc_q     <= 2'b00;
            n_q        <= '0;
            v1_q       <= '0;
            v2_q       <= '0;
        end else begin
            stato_q    <= stato_d;
            primo_q    <= primo_d;
            secondo_q  <= secondo_d;
            inizia_q   <= inizia_d;
            in_corso_q <= in_corso_d;
            fine_q     <= fine_d;
            timeout_q  <= timeout_d;
            vinc_q     <= vinc_d;
            n_q        <= n_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
        end
    end

    assign PRIMO      = primo_q;
    assign SECONDO    = secondo_q;
    assign INIZIA     = inizia_q;
    assign IN_CORSO   = in_corso_q;
    assign FINE       = fine_q;
    assign TIMEOUT    = timeout_q;
    assign VINCITORE  = vinc_q;
    assign N_MANCHE   = n_q;
    assign VITTORIE_1 = v1_q;
    assign VITTORIE_2 = v2_q;

endmodule

// File: tb/tb_generatore_mosse.sv
// Scoreboard bench: two generator instances (short round limit / default) against a match-level model.
module tb_generatore_mosse;

    typedef struct packed {
        logic [1:0] primo;
        logic [1:0] secondo;
        logic       inizia;
        logic       in_corso;
        logic       fine;
        logic [1:0] vinc;
        logic       timeout;
        logic [4:0] n;
        logic [4:0] v1;
        logic [4:0] v2;
    } outs_t;

    typedef struct packed {
        outs_t a;
        outs_t b;
    } pair_t;

    logic       clk;
    logic       RESET, AVVIA;
    logic [1:0] MANCHE, PARTITA;

    logic [1:0] a_primo, a_secondo, a_vinc, b_primo, b_secondo, b_vinc;
    logic       a_inizia, a_in_corso, a_fine, a_timeout;
    logic       b_inizia, b_in_corso, b_fine, b_timeout;
    logic [4:0] a_n, a_v1, a_v2, b_n, b_v1, b_v2;

    outs_t act_a, act_b;
    assign act_a = {a_primo, a_secondo, a_inizia, a_in_corso, a_fine, a_vinc, a_timeout, a_n, a_v1, a_v2};
    assign act_b = {b_primo, b_secondo, b_inizia, b_in_corso, b_fine, b_vinc, b_timeout, b_n, b_v1, b_v2};

    generatore_mosse #(.SEED_1(8'h01), .SEED_2(8'h02), .MAX_MANCHE(3)) dut_a (
        .clk(clk), .RESET(RESET), .AVVIA(AVVIA), .MANCHE(MANCHE), .PARTITA(PARTITA),
        .PRIMO(a_primo), .SECONDO(a_secondo), .INIZIA(a_inizia), .IN_CORSO(a_in_corso),
        .FINE(a_fine), .VINCITORE(a_vinc), .TIMEOUT(a_timeout), .N_MANCHE(a_n),
        .VITTORIE_1(a_v1), .VITTORIE_2(a_v2)
    );

    // Default seed 1 and round limit; seed 2 of zero exercises the seed substitution.
    generatore_mosse #(.SEED_2(8'h00)) dut_b (
        .clk(clk), .RESET(RESET), .AVVIA(AVVIA), .MANCHE(MANCHE), .PARTITA(PARTITA),
        .PRIMO(b_primo), .SECONDO(b_secondo), .INIZIA(b_inizia), .IN_CORSO(b_in_corso),
        .FINE(b_fine), .VINCITORE(b_vinc), .TIMEOUT(b_timeout), .N_MANCHE(b_n),
        .VITTORIE_1(b_v1), .VITTORIE_2(b_v2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    pair_t exp_q[$];

    // Model state: phase 0 idle, 1 start, 2 playing, 3 finished.
    int    ph [2];
    int    l1 [2];
    int    l2 [2];
    outs_t mo [2];

    function automatic int seed1(input int d);
        return (d == 0) ? 1 : 165;
    endfunction

    function automatic int seed2(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int maxr(input int d);
        return (d == 0) ? 3 : 31;
    endfunction

    function automatic int nx(input int l);
        int fb;
        fb = (l / 128 + (l / 32) % 2 + (l / 16) % 2 + (l / 8) % 2) % 2;
        return (l * 2) % 256 + fb;
    endfunction

    function automatic int mv(input int l);
        return (l % 4 == 0) ? 1 : l % 4;
    endfunction

    function automatic string fmt(input outs_t o);
        return $sformatf("primo=%0d secondo=%0d inizia=%0d in_corso=%0d fine=%0d vinc=%0d timeout=%0d n=%0d v1=%0d v2=%0d",
                         o.primo, o.secondo, o.inizia, o.in_corso, o.fine, o.vinc, o.timeout, o.n, o.v1, o.v2);
    endfunction

    task automatic model_step(input int d, input logic rst, input logic av, input logic [1:0] m, input logic [1:0] p);
        outs_t o;
        bit    finish;
        o      = mo[d];
        finish = 1'b0;
        if (rst) begin
            o     = '0;
            ph[d] = 0;
        end else if (ph[d] == 0 || ph[d] == 3) begin
            if (av) begin
                o         = '0;
                o.inizia  = 1'b1;
                ph[d]     = 1;
                l1[d]     = seed1(d);
                l2[d]     = seed2(d);
                o.primo   = 2'(mv(l1[d]));
                o.secondo = 2'(mv(l2[d]));
            end
        end else begin
            l1[d]      = nx(l1[d]);
            l2[d]      = nx(l2[d]);
            o.inizia   = 1'b0;
            o.in_corso = 1'b1;
            o.primo    = 2'(mv(l1[d]));
            o.secondo  = 2'(mv(l2[d]));
            if (ph[d] == 1) begin
                ph[d] = 2;
            end else begin
                if (m != 2'b00 && o.n < 5'd31) o.n  = o.n + 5'd1;
                if (m == 2'b01 && o.v1 < 5'd31) o.v1 = o.v1 + 5'd1;
                if (m == 2'b10 && o.v2 < 5'd31) o.v2 = o.v2 + 5'd1;
                if (p != 2'b00) begin
                    finish = 1'b1;
                    o.vinc = p;
                end else if (m != 2'b00 && int'(o.n) == maxr(d)) begin
                    finish    = 1'b1;
                    o.timeout = 1'b1;
                    o.vinc    = 2'b11;
                end
            end
            if (finish) begin
                ph[d]      = 3;
                o.fine     = 1'b1;
                o.in_corso = 1'b0;
                o.primo    = 2'b00;
                o.secondo  = 2'b00;
            end
        end
        mo[d] = o;
    endtask

    // Apply one cycle of inputs, queue the expected post-edge outputs, advance one clock.
    task automatic step(input logic rst, input logic av, input logic [1:0] m, input logic [1:0] p);
        RESET   = rst;
        AVVIA   = av;
        MANCHE  = m;
        PARTITA = p;
        model_step(0, rst, av, m, p);
        model_step(1, rst, av, m, p);
        exp_q.push_back('{a: mo[0], b: mo[1]});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic compare(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got {%s} expected {%s}", name, $time, fmt(act), fmt(exp));
        end
    endtask

    task automatic moves_live(input string name, input outs_t act);
        if (act.inizia || act.in_corso) begin
            checks++;
            if (act.primo == 2'b00 || act.secondo == 2'b00) begin
                failures++;
                $display("FAIL %s idle move during match: got primo=%0d secondo=%0d required nonzero", name, act.primo, act.secondo);
            end
        end
    endtask

    task automatic monitor_loop();
        pair_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare("dut_a", act_a, e.a);
                compare("dut_b", act_b, e.b);
                moves_live("dut_a", act_a);
                moves_live("dut_b", act_b);
            end
        end
    endtask

    task automatic spot(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        RESET   = 1'b1;
        AVVIA   = 1'b0;
        MANCHE  = 2'b00;
        PARTITA = 2'b00;
        fork
            monitor_loop();
        join_none

        step(1'b1, 1'b0, 2'b00, 2'b00);
        step(1'b1, 1'b1, 2'b00, 2'b00);
        spot("reset_beats_avvia_inizia", int'(a_inizia), 0);
        spot("reset_all_zero_a", int'(act_a), 0);

        step(1'b0, 1'b1, 2'b00, 2'b00);
        spot("first_primo", int'(a_primo), 1);
        spot("first_secondo", int'(a_secondo), 2);
        spot("start_inizia", int'(a_inizia), 1);
        step(1'b0, 1'b0, 2'b00, 2'b00);
        spot("play_inizia", int'(a_inizia), 0);
        spot("play_in_corso", int'(a_in_corso), 1);

        step(1'b0, 1'b0, 2'b01, 2'b00);
        step(1'b0, 1'b0, 2'b10, 2'b00);
        step(1'b0, 1'b0, 2'b11, 2'b00);
        step(1'b0, 1'b0, 2'b01, 2'b00);
        spot("tally_n", int'(b_n), 4);
        spot("tally_v1", int'(b_v1), 2);
        spot("tally_v2", int'(b_v2), 1);
        spot("a_timeout_vinc", int'(a_vinc), 3);
        spot("a_timeout_n", int'(a_n), 3);

        step(1'b0, 1'b0, 2'b10, 2'b10);
        spot("result_fine", int'(b_fine), 1);
        spot("result_vinc", int'(b_vinc), 2);
        spot("result_v2", int'(b_v2), 2);
        spot("result_moves", int'({b_primo, b_secondo}), 0);

        step(1'b0, 1'b1, 2'b00, 2'b00);
        step(1'b0, 1'b0, 2'b00, 2'b00);
        repeat (3) step(1'b0, 1'b0, 2'b11, 2'b00);
        spot("limit_fine", int'(a_fine), 1);
        spot("limit_timeout", int'(a_timeout), 1);
        spot("limit_vinc", int'(a_vinc), 3);
        spot("limit_n", int'(a_n), 3);

        step(1'b0, 1'b1, 2'b00, 2'b00);
        spot("avvia_in_play_inizia", int'(b_inizia), 0);
        spot("avvia_in_play_n", int'(b_n), 3);

        step(1'b0, 1'b0, 2'b01, 2'b00);
        step(1'b1, 1'b0, 2'b00, 2'b00);
        spot("midplay_reset_b", int'(act_b), 0);
        step(1'b0, 1'b1, 2'b00, 2'b00);
        spot("restart_primo", int'(a_primo), 1);
        spot("restart_secondo", int'(a_secondo), 2);

        repeat (240) begin
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 7) == 0,
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
